// File: rtl/axi_write_if.sv
// AXI4 write-channel slave bridging single-outstanding bursts onto a one-beat-at-a-time internal write port.
// Optional debug outputs are enabled with the AXI_WR_DEBUG_EN macro.
module axi_write_if (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  AWID,
    input  logic [10:0] AWADDR,
    input  logic [7:0]  AWLEN,
    input  logic [2:0]  AWSIZE,
    input  logic [1:0]  AWBURST,
    input  logic [3:0]  AWREGION,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WLAST,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [7:0]  BID,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    output logic        axi_wr_vld,
    output logic [10:0] axi_wr_addr,
    output logic [31:0] axi_wr_data,
    output logic [3:0]  axi_wr_strb,
    output logic [1:0]  axi_wr_region,
    input  logic        fifo_wr_done,
    input  logic        fifo_err,
    input  logic        iram_wr_done,
    input  logic        wram_wr_done
`ifdef AXI_WR_DEBUG_EN
    ,
    output logic        axi_wr_doing,
    output logic        axi_wr_finish,
    output logic [7:0]  axi_wr_beat_cnt
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_WAIT, ST_RESP} state_t;

    state_t      state_r, state_nxt_s;
    logic        awready_r, awready_nxt_s;
    logic        wready_r, wready_nxt_s;
    logic        bvalid_r, bvalid_nxt_s;
    logic [7:0]  bid_r, bid_nxt_s;
    logic [1:0]  bresp_r, bresp_nxt_s;
    logic        vld_r, vld_nxt_s;
    logic [10:0] wr_addr_r, wr_addr_nxt_s;
    logic [31:0] wr_data_r, wr_data_nxt_s;
    logic [3:0]  wr_strb_r, wr_strb_nxt_s;
    logic [1:0]  wr_region_r, wr_region_nxt_s;
    logic [7:0]  id_r, id_nxt_s;
    logic [10:0] addr_r, addr_nxt_s;
    logic [7:0]  len_r, len_nxt_s;
    logic [1:0]  burst_r, burst_nxt_s;
    logic [1:0]  region_r, region_nxt_s;
    logic [7:0]  cnt_r, cnt_nxt_s;
    logic        err_r, err_nxt_s;
    logic        finish_r, finish_nxt_s;
    logic        beat_done_s;
    logic        last_beat_s;
    logic        unused_s;

    assign unused_s = &{1'b0, AWREGION[3:2]};

    // Next word address; WRAP keeps the upper bits of an aligned (len+1)*4 byte window.
    function automatic logic [10:0] next_addr(input logic [10:0] a, input logic [1:0] burst,
                                              input logic [7:0] len);
        logic [10:0] inc;
        logic [10:0] win_mask;
        inc      = a + 11'd4;
        win_mask = ({3'd0, len} << 2) | 11'h003;
        case (burst)
            2'b00:   next_addr = a;
            2'b10:   next_addr = (a & ~win_mask) | (inc & win_mask);
            default: next_addr = inc;
        endcase
    endfunction

    assign last_beat_s = (cnt_r == len_r);

    // Select the completion strobe belonging to the latched region.
    always_comb begin
        case (region_r)
            2'd0:    beat_done_s = fifo_wr_done;
            2'd1:    beat_done_s = iram_wr_done;
            2'd2:    beat_done_s = wram_wr_done;
            default: beat_done_s = 1'b1;
        endcase
    end

    // Next-state and next-output computation for the burst FSM.
    always_comb begin
        state_nxt_s     = state_r;
        awready_nxt_s   = awready_r;
        wready_nxt_s    = wready_r;
        bvalid_nxt_s    = bvalid_r;
        bid_nxt_s       = bid_r;
        bresp_nxt_s     = bresp_r;
        vld_nxt_s       = 1'b0;
        wr_addr_nxt_s   = wr_addr_r;
        wr_data_nxt_s   = wr_data_r;
        wr_strb_nxt_s   = wr_strb_r;
        wr_region_nxt_s = wr_region_r;
        id_nxt_s        = id_r;
        addr_nxt_s      = addr_r;
        len_nxt_s       = len_r;
        burst_nxt_s     = burst_r;
        region_nxt_s    = region_r;
        cnt_nxt_s       = cnt_r;
        err_nxt_s       = err_r;
        finish_nxt_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (AWVALID && awready_r) begin
                    id_nxt_s      = AWID;
                    addr_nxt_s    = AWADDR;
                    len_nxt_s     = AWLEN;
                    burst_nxt_s   = AWBURST;
                    region_nxt_s  = AWREGION[1:0];
                    cnt_nxt_s     = 8'd0;
                    err_nxt_s     = (AWSIZE != 3'b010) || (AWBURST == 2'b11);
                    awready_nxt_s = 1'b0;
                    wready_nxt_s  = 1'b1;
                    state_nxt_s   = ST_DATA;
                end else begin
                    awready_nxt_s = 1'b1;
                end
            end
            ST_DATA: begin
                if (WVALID && wready_r) begin
                    wready_nxt_s    = 1'b0;
                    wr_data_nxt_s   = WDATA;
                    wr_strb_nxt_s   = WSTRB;
                    wr_addr_nxt_s   = addr_r;
                    wr_region_nxt_s = region_r;
                    vld_nxt_s       = (region_r != 2'd3);
                    if ((region_r == 2'd3) || (WLAST != last_beat_s)) begin
                        err_nxt_s = 1'b1;
                    end else begin
                        err_nxt_s = err_r;
                    end
                    state_nxt_s     = ST_WAIT;
                end else begin
                    wready_nxt_s = 1'b1;
                end
            end
            ST_WAIT: begin
                if ((region_r == 2'd0) && fifo_err) begin
                    err_nxt_s = 1'b1;
                end else begin
                    err_nxt_s = err_r;
                end
                // The response must reflect an error reported on the final completion cycle.
                if (beat_done_s && last_beat_s) begin
                    bvalid_nxt_s = 1'b1;
                    bid_nxt_s    = id_r;
                    bresp_nxt_s  = err_nxt_s ? 2'b10 : 2'b00;
                    finish_nxt_s = 1'b1;
                    state_nxt_s  = ST_RESP;
                end else if (beat_done_s) begin
                    cnt_nxt_s    = cnt_r + 8'd1;
                    addr_nxt_s   = next_addr(addr_r, burst_r, len_r);
                    wready_nxt_s = 1'b1;
                    state_nxt_s  = ST_DATA;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (BREADY) begin
                    bvalid_nxt_s  = 1'b0;
                    awready_nxt_s = 1'b1;
                    state_nxt_s   = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            awready_r   <= 1'b0;
            wready_r    <= 1'b0;
            bvalid_r    <= 1'b0;
            bid_r       <= 8'd0;
            bresp_r     <= 2'd0;
            vld_r       <= 1'b0;
            wr_addr_r   <= 11'd0;
            wr_data_r   <= 32'd0;
            wr_strb_r   <= 4'd0;
            wr_region_r <= 2'd0;
            id_r        <= 8'd0;
            addr_r      <= 11'd0;
            len_r       <= 8'd0;
            burst_r     <= 2'd0;
            region_r    <= 2'd0;
            cnt_r       <= 8'd0;
            err_r       <= 1'b0;
            finish_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            awready_r   <= awready_nxt_s;
            wready_r    <= wready_nxt_s;
            bvalid_r    <= bvalid_nxt_s;
            bid_r       <= bid_nxt_s;
            bresp_r     <= bresp_nxt_s;
            vld_r       <= vld_nxt_s;
            wr_addr_r   <= wr_addr_nxt_s;
            wr_data_r   <= wr_data_nxt_s;
            wr_strb_r   <= wr_strb_nxt_s;
            wr_region_r <= wr_region_nxt_s;
            id_r        <= id_nxt_s;
            addr_r      <= addr_nxt_s;
            len_r       <= len_nxt_s;
            burst_r     <= burst_nxt_s;
            region_r    <= region_nxt_s;
            cnt_r       <= cnt_nxt_s;
            err_r       <= err_nxt_s;
            finish_r    <= finish_nxt_s;
        end
    end

    assign AWREADY       = awready_r;
    assign WREADY        = wready_r;
    assign BVALID        = bvalid_r;
    assign BID           = bid_r;
    assign BRESP         = bresp_r;
    assign axi_wr_vld    = vld_r;
    assign axi_wr_addr   = wr_addr_r;
    assign axi_wr_data   = wr_data_r;
    assign axi_wr_strb   = wr_strb_r;
    assign axi_wr_region = wr_region_r;

`ifdef AXI_WR_DEBUG_EN
    assign axi_wr_doing    = (state_r == ST_DATA) || (state_r == ST_WAIT);
    assign axi_wr_finish   = finish_r;
    assign axi_wr_beat_cnt = cnt_r;
`else
    logic unused_dbg_s;
    assign unused_dbg_s = &{1'b0, finish_r};
`endif

endmodule

// File: tb/tb_axi_write_if.sv
// Self-checking bench for axi_write_if: directed and randomized bursts against a
// behavioural model of addresses, beat counts and response codes.
module tb_axi_write_if;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  AWID = 8'd0;
    logic [10:0] AWADDR = 11'd0;
    logic [7:0]  AWLEN = 8'd0;
    logic [2:0]  AWSIZE = 3'd0;
    logic [1:0]  AWBURST = 2'd0;
    logic [3:0]  AWREGION = 4'd0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = 32'd0;
    logic [3:0]  WSTRB = 4'd0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [7:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic        axi_wr_vld;
    logic [10:0] axi_wr_addr;
    logic [31:0] axi_wr_data;
    logic [3:0]  axi_wr_strb;
    logic [1:0]  axi_wr_region;
    logic        fifo_wr_done = 1'b0;
    logic        fifo_err = 1'b0;
    logic        iram_wr_done = 1'b0;
    logic        wram_wr_done = 1'b0;
`ifdef AXI_WR_DEBUG_EN
    logic        axi_wr_doing;
    logic        axi_wr_finish;
    logic [7:0]  axi_wr_beat_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int vld_seen = 0;

    axi_write_if dut (
        .clk(clk), .rst_n(rst_n),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWREGION(AWREGION), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .axi_wr_vld(axi_wr_vld), .axi_wr_addr(axi_wr_addr), .axi_wr_data(axi_wr_data),
        .axi_wr_strb(axi_wr_strb), .axi_wr_region(axi_wr_region),
        .fifo_wr_done(fifo_wr_done), .fifo_err(fifo_err),
        .iram_wr_done(iram_wr_done), .wram_wr_done(wram_wr_done)
`ifdef AXI_WR_DEBUG_EN
        ,
        .axi_wr_doing(axi_wr_doing), .axi_wr_finish(axi_wr_finish),
        .axi_wr_beat_cnt(axi_wr_beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Count beat strobes mid-cycle so a strobe longer than one cycle is counted twice.
    always @(negedge clk) begin
        if (axi_wr_vld) vld_seen <= vld_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference address of beat i, from the burst rules directly.
    function automatic logic [10:0] model_addr(input int a, input int burst, input int len, input int i);
        int win;
        int base;
        win = (len + 1) * 4;
        if (burst == 0) return a[10:0];
        if (burst == 2) begin
            base = (a / win) * win;
            return 11'(base + ((a - base) + 4 * i) % win);
        end
        return 11'((a + 4 * i) % 2048);
    endfunction

    task automatic drive_done(input int region, input logic en, input logic ferr);
        fifo_wr_done = en && (region == 0);
        iram_wr_done = en && (region == 1);
        wram_wr_done = en && (region == 2);
        fifo_err     = ferr;
    endtask

    task automatic run_burst(input int id, input int addr, input int len, input int burst,
                             input int size, input int region, input int bad_last,
                             input int ferr_beat, input int bdelay, input int data_base);
        int t;
        int vld_start;
        int extra;
        logic [10:0] exp_a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        exp_err;
        exp_err = (size != 2) || (burst == 3) || (region == 3) || (bad_last >= 0) ||
                  ((region == 0) && (ferr_beat >= 0));
        @(negedge clk);
        t = 0;
        while (!AWREADY && t < 20) begin @(negedge clk); t++; end
        chk("awready_idle", AWREADY, 1);
        vld_start = vld_seen;
        AWID = 8'(id); AWADDR = 11'(addr); AWLEN = 8'(len); AWSIZE = 3'(size);
        AWBURST = 2'(burst); AWREGION = 4'(region) | 4'(($urandom & 3) << 2); AWVALID = 1'b1;
        @(posedge clk); #1;
        AWVALID = 1'b0;
        chk("aw_accept_awready", AWREADY, 0);
        for (int i = 0; i <= len; i++) begin
            exp_a = model_addr(addr, burst, len, i);
            d = (data_base >= 0) ? 32'(data_base + i) : $urandom;
            s = (data_base >= 0) ? 4'hF : 4'($urandom);
            @(negedge clk);
            WVALID = 1'b1; WDATA = d; WSTRB = s; WLAST = (i == len) ^ (i == bad_last);
            t = 0;
            while (!WREADY && t < 20) begin @(negedge clk); t++; end
            chk("wready_data", WREADY, 1);
            @(posedge clk); #1;
            WVALID = 1'b0; WLAST = 1'b0;
            chk("wready_drop", WREADY, 0);
            if (region == 3) begin
                chk("vld_region3", axi_wr_vld, 0);
            end else begin
                chk("vld_pulse", axi_wr_vld, 1);
                chk("wr_addr", axi_wr_addr, exp_a);
                chk("wr_data", axi_wr_data, d);
                chk("wr_strb", axi_wr_strb, s);
                chk("wr_region", axi_wr_region, region);
                extra = $urandom_range(0, 2);
                for (int k = 0; k < extra; k++) begin
                    @(negedge clk);
                    fifo_wr_done = (region != 0); iram_wr_done = (region != 1);
                    wram_wr_done = (region != 2); fifo_err = (region != 0) && $urandom_range(0, 1) == 1;
                end
                @(negedge clk);
                drive_done(region, 1'b1, (i == ferr_beat));
                if (extra > 0) begin
                    chk("vld_single", axi_wr_vld, 0);
                    chk("wait_hold_addr", axi_wr_addr, exp_a);
                    chk("wait_no_wready", WREADY, 0);
                end
                @(negedge clk);
                drive_done(region, 1'b0, 1'b0);
                chk("post_done_vld", axi_wr_vld, 0);
                chk("post_done_data", axi_wr_data, d);
            end
        end
        t = 0;
        while (!BVALID && t < 20) begin @(negedge clk); t++; end
        chk("bvalid", BVALID, 1);
        chk("bid", BID, id);
        chk("bresp", BRESP, exp_err ? 2'b10 : 2'b00);
        chk("resp_awready", AWREADY, 0);
        for (int k = 0; k < bdelay; k++) begin
            @(negedge clk);
            chk("bp_bvalid", BVALID, 1);
            chk("bp_bid", BID, id);
            chk("bp_awready", AWREADY, 0);
        end
        BREADY = 1'b1;
        @(posedge clk); #1;
        BREADY = 1'b0;
        chk("b_done_bvalid", BVALID, 0);
        chk("b_done_awready", AWREADY, 1);
        chk("vld_count", vld_seen - vld_start, (region == 3) ? 0 : len + 1);
    endtask

    initial begin
        int lens[4];
        int bsel;
        int ln;
        lens[0] = 1; lens[1] = 3; lens[2] = 7; lens[3] = 15;
        #2;
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_bid_bresp", {BID, BRESP}, 0);
        chk("rst_wr_port", {axi_wr_vld, axi_wr_addr, axi_wr_strb, axi_wr_region}, 0);
        chk("rst_wr_data", axi_wr_data, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        chk("release_awready_low", AWREADY, 0);
        @(posedge clk); #1;
        chk("release_awready_high", AWREADY, 1);

        // id, addr, len, burst, size, region, bad_last, ferr_beat, bdelay, data_base
        run_burst(1, 'h000, 0, 1, 2, 1, -1, -1, 0, 10);
        run_burst(2, 'h010, 3, 1, 2, 2, -1, -1, 1, 10);
        run_burst(3, 'h008, 3, 2, 2, 1, -1, -1, 0, -1);
        run_burst(4, 'h100, 2, 1, 2, 0, -1, 1, 0, -1);
        run_burst(5, 'h040, 1, 1, 2, 3, -1, -1, 0, -1);
        run_burst(6, 'h020, 1, 1, 2, 2, -1, -1, 5, -1);
        run_burst(7, 'h030, 1, 1, 1, 1, -1, -1, 0, -1);
        run_burst(8, 'h7F8, 3, 3, 2, 2, -1, -1, 0, -1);
        run_burst(9, 'h050, 2, 1, 2, 0, 0, -1, 0, -1);
        run_burst(10, 'h060, 2, 1, 2, 1, 2, -1, 0, -1);
        run_burst(11, 'h070, 2, 0, 2, 2, -1, -1, 0, -1);
        run_burst(12, 'h7F8, 3, 1, 2, 0, -1, -1, 0, -1);

        for (int r = 0; r < 12; r++) begin
            bsel = $urandom_range(0, 2);
            ln = (bsel == 2) ? lens[$urandom_range(0, 3)] : $urandom_range(0, 5);
            run_burst($urandom_range(0, 255), $urandom_range(0, 511) * 4, ln, bsel, 2,
                      $urandom_range(0, 3), -1,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, ln) : -1,
                      $urandom_range(0, 3), -1);
        end

        // Reset in the middle of a burst.
        @(negedge clk);
        AWID = 8'h5A; AWADDR = 11'h080; AWLEN = 8'd3; AWSIZE = 3'd2; AWBURST = 2'b01;
        AWREGION = 4'd2; AWVALID = 1'b1;
        @(negedge clk);
        AWVALID = 1'b0; WVALID = 1'b1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WLAST = 1'b0;
        @(negedge clk);
        WVALID = 1'b0;
        chk("mid_vld_before_rst", axi_wr_vld, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", axi_wr_vld, 0);
        chk("mid_rst_ready", {AWREADY, WREADY, BVALID}, 0);
        chk("mid_rst_port", {axi_wr_addr, axi_wr_strb, axi_wr_region, BID, BRESP}, 0);
        chk("mid_rst_data", axi_wr_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_release_awready_low", AWREADY, 0);
        @(posedge clk); #1;
        chk("mid_release_awready", AWREADY, 1);
        chk("mid_release_wready", WREADY, 0);
        run_burst(13, 'h0C0, 1, 1, 2, 1, -1, -1, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi_write_if.md
AXI_WRITE_IF -- requirements
Module: axi_write_if

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk (in, 1) is the rising-edge clock; rst_n (in, 1) is the async active-low reset.
REQ-002 SHALL provide the AW channel: AWID in 8; AWADDR in 11 (byte address); AWLEN in 8 (beats-1); AWSIZE in 3; AWBURST in 2; AWREGION in 4; AWVALID in 1; AWREADY out 1.
REQ-003 SHALL provide the W channel: WDATA in 32; WSTRB in 4; WLAST in 1; WVALID in 1; WREADY out 1.
REQ-004 SHALL provide the B channel: BID out 8; BRESP out 2; BVALID out 1; BREADY in 1.
REQ-005 SHALL provide the internal write port: axi_wr_vld out 1 (one-cycle beat strobe); axi_wr_addr out 11; axi_wr_data out 32; axi_wr_strb out 4; axi_wr_region out 2 (region target: 0 fifo, 1 iram, 2 wram, 3 invalid).
REQ-006 SHALL provide target completion inputs: fifo_wr_done in 1; fifo_err in 1; iram_wr_done in 1; wram_wr_done in 1.

Function
REQ-007 SHALL implement FSM IDLE -> DATA -> WAIT -> (DATA | RESP) -> IDLE.
REQ-008 IDLE: AWREADY=1; on AWVALID&AWREADY latch AWID, AWADDR, AWLEN, AWBURST, AWSIZE, AWREGION[1:0]; clear beat counter and error flag; next state DATA with AWREADY=0.
REQ-009 DATA: WREADY=1; on WVALID&WREADY register WDATA/WSTRB, present with current address and region, pulse axi_wr_vld for exactly one cycle (the cycle after the handshake); WREADY=0; go WAIT.
REQ-010 WAIT: hold axi_wr_* outputs stable; leave WAIT on the done input of the latched region (0 fifo_wr_done, 1 iram_wr_done, 2 wram_wr_done); done inputs of other regions ignored.
REQ-011 Region 3: no axi_wr_vld pulse, beat completes next cycle, error flag set.
REQ-012 fifo_err high in WAIT with region 0 sets the sticky error flag.
REQ-013 Address step SHALL be 4 bytes per beat: FIXED(00) constant; INCR(01) +4 modulo 2048; WRAP(10) +4 wrapping within an aligned (AWLEN+1)*4 byte window; burst 11 treated as INCR with error.
REQ-014 AWSIZE other than 3'b010 SHALL set the error flag; beats still consumed normally.
REQ-015 Beat done with counter==AWLEN -> RESP; otherwise counter+1, address updated, -> DATA.
REQ-016 WLAST asserted on a non-final beat, or deasserted on the final beat, SHALL set the error flag; length governed by AWLEN only.
REQ-017 RESP: BVALID=1, BID=latched AWID, BRESP=2'b10 (SLVERR) if error flag else 2'b00; held until BREADY; on BVALID&BREADY -> IDLE, AWREADY=1 next cycle.
REQ-018 Only one outstanding transaction; AW not accepted outside IDLE; W not accepted outside DATA.

Reset
REQ-019 rst_n low SHALL immediately force IDLE, aborting any burst: AWREADY, WREADY, BVALID, axi_wr_vld = 0; BID, BRESP, axi_wr_addr, axi_wr_data, axi_wr_strb, axi_wr_region, and the internal counter and error flag = 0.
REQ-020 AWREADY SHALL rise on the first clock edge after rst_n deasserts.

Configuration
REQ-021 Macro AXI_WR_DEBUG_EN defined: SHALL add outputs axi_wr_doing (1 in DATA/WAIT), axi_wr_finish (1-cycle pulse on the final beat done), axi_wr_beat_cnt (8, current counter). Undefined: these ports are absent, functionality is identical.

Verification
REQ-022 Single beat: AWADDR=0, AWLEN=0, AWREGION=1, WDATA=10, WSTRB=4'hF, WLAST=1, iram_wr_done pulse -> axi_wr_vld one cycle with addr 0/data 10/region 1; BVALID with BID=1, BRESP=00.
REQ-023 INCR 4 beats: AWADDR=0x10, AWLEN=3, region 2, data 10..13 -> addresses 0x10, 0x14, 0x18, 0x1C; four vld pulses, each gated by wram_wr_done; BRESP=00.
REQ-024 WRAP: AWADDR=0x08, AWLEN=3, burst 10 -> addresses 0x08, 0x0C, 0x00, 0x04.
REQ-025 Errors: region 0 with fifo_err=1 during WAIT, then separately AWREGION=3 -> BRESP=10 in both cases; no vld pulse for region 3.
REQ-026 Backpressure/reset: BREADY=0 for 5 cycles -> BVALID and BID held stable, AWREADY=0; rst_n low mid-burst -> all outputs 0, then AWREADY=1 on the next edge after release.
